rr_arbiter32: RTL and testbench

Round-robin arbiter that shares one decoded resource slot (a 32-way select line) among 32 requesters. It registers a 5-bit winner index and drives the matching one-hot grant vector through a 5-to-32 decoder with enable. It holds the grant until the owner releases or a hold timeout expires. It sits in front of any 32-entry select/write-enable decode, e.g. a register-file write port.

---
 rtl/rr_arb_pkg.sv | 17 +
 rtl/rr_arbiter32_if.sv | 20 ++
 rtl/gnt_dec5t32.sv | 15 +
 rtl/rr_arbiter32.sv | 106 ++++++++++
 tb/tb_rr_arbiter32.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and hold-counter sizing for rr_arbiter32.
package rr_arb_pkg;

  localparam int NREQ         = 32;
  localparam int IDX_W        = 5;
  localparam int DEF_MAX_HOLD = 16;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Hold counter only has to reach MAX_HOLD-1, so $clog2(MAX_HOLD) bits suffice.
  function automatic int hold_w(input int max_hold);
    return (max_hold < 2) ? 1 : $clog2(max_hold);
  endfunction

  localparam int HOLD_W = hold_w(DEF_MAX_HOLD);

endpackage

// File: rtl/rr_arbiter32_if.sv
// Request/grant bundle between 32 requesters (master) and rr_arbiter32 (slave).
// Handshake: the owner keeps req[gnt_idx] high while gnt_valid=1. A grant ends
// after rel=1 or req[gnt_idx]=0 is seen at a rising edge, or when timeout pulses.
// gnt_idx is only meaningful while gnt_valid=1.
interface rr_arbiter32_if;
  import rr_arb_pkg::*;

  logic              en;
  logic [NREQ-1:0]   req;
  logic              rel;
  logic              gnt_valid;
  logic [IDX_W-1:0]  gnt_idx;
  logic [NREQ-1:0]   gnt_onehot;
  logic              timeout;

  modport master (output en, req, rel,
                  input  gnt_valid, gnt_idx, gnt_onehot, timeout);
  modport slave  (input  en, req, rel,
                  output gnt_valid, gnt_idx, gnt_onehot, timeout);
endinterface

// File: rtl/gnt_dec5t32.sv
// 5-to-32 one-hot decoder with enable; output is all zeros when en=0.
module gnt_dec5t32
  import rr_arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [NREQ-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter32.sv
// 32-way round-robin arbiter with registered grant index and MAX_HOLD revoke.
// Define RR_ARB_FIXED_PRIO_EN to pin the scan pointer at 0 (fixed priority).
module rr_arbiter32
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter32_if.slave bus,
  output state_t        dbg_state
);

  localparam int CNT_W = hold_w(MAX_HOLD);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [NREQ-1:0]   rot;
  logic [IDX_W-1:0]  off;
  logic [IDX_W-1:0]  winner;
  logic              found;
  logic              exit_gnt;
  logic              timeout;

  // Rotate so ptr lands at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot   = (bus.req >> ptr) | (bus.req << (NREQ - int'(ptr)));
    found = 1'b0;
    off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = IDX_W'(i);
      end
    end
    winner = off + ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    exit_gnt  = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.en && found) begin
          idx_nxt   = winner;
          cnt_nxt   = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        cnt_nxt = cnt + CNT_W'(1);
        // Priority: release, then owner drop, then forced revoke.
        if (bus.rel) begin
          exit_gnt = 1'b1;
        end else if (!bus.req[idx]) begin
          exit_gnt = 1'b1;
        end else if (cnt == CNT_W'(MAX_HOLD - 1)) begin
          exit_gnt = 1'b1;
          timeout  = 1'b1;
        end
        if (exit_gnt) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
`ifdef RR_ARB_FIXED_PRIO_EN
          ptr_nxt   = '0;
`else
          ptr_nxt   = idx + IDX_W'(1);
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.gnt_valid = (state == BUSY);
  assign bus.gnt_idx   = idx;
  assign bus.timeout   = timeout;
  assign dbg_state     = state;

  gnt_dec5t32 u_dec (
    .idx    (idx),
    .en     (state == BUSY),
    .onehot (bus.gnt_onehot)
  );

endmodule

// File: tb/tb_rr_arbiter32.sv
// Directed bench for rr_arbiter32: grant order is tracked by an expected queue.
module tb_rr_arbiter32;
  import rr_arb_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     tests;
  int     fails;
  logic   prev_v;
  logic [31:0] exp_q[$];

  rr_arbiter32_if bus ();

  rr_arbiter32 #(.MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge; score any newly started grant.
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (bus.gnt_valid === 1'b1 && prev_v !== 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_grant: observed idx %0d expected none", bus.gnt_idx);
      end else begin
        e = exp_q.pop_front();
        chk("grant_idx", 32'(bus.gnt_idx), e);
        chk("grant_onehot", bus.gnt_onehot, 32'h1 << e[4:0]);
      end
    end
    prev_v = bus.gnt_valid;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(bus.gnt_valid), 32'h0);
    chk({tag, "_onehot"}, bus.gnt_onehot, 32'h0);
    chk({tag, "_timeout"}, 32'(bus.timeout), 32'h0);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    prev_v  = 1'b0;
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.req = '0;
    bus.rel = 1'b0;
    #12;
    chk_idle("reset");
    chk("reset_idx", 32'(bus.gnt_idx), 32'h0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    tick();
    rst_n = 1'b1;
    tick();

    // basic grant, release, one idle cycle, next requester
    bus.en = 1'b1; bus.req = 32'h0000_0005; exp_q.push_back(0);
    tick();
    chk("t1_state", 32'(dbg_state), 32'(BUSY));
    bus.rel = 1'b1;
    tick();
    chk_idle("t1_gap");
    bus.rel = 1'b0; exp_q.push_back(2);
    tick();
    chk("t1_idx2", 32'(bus.gnt_idx), 32'd2);
    bus.rel = 1'b1; bus.req = '0;
    tick();
    bus.rel = 1'b0;
    tick();
    chk_idle("t1_noreq");

    // wrap: 30 -> 31 -> 0 -> 1
    bus.req = 32'h4000_0000; exp_q.push_back(30);
    tick();
    bus.req = 32'h8000_0001; bus.rel = 1'b1;
    tick();
    bus.rel = 1'b0; exp_q.push_back(31);
    tick();
    bus.rel = 1'b1;
    tick();
    bus.rel = 1'b0; exp_q.push_back(0);
    tick();
    bus.rel = 1'b1; bus.req = '0;
    tick();
    bus.rel = 1'b0; bus.req = 32'h0000_0003; exp_q.push_back(1);
    tick();
    bus.rel = 1'b1; bus.req = '0;
    tick();
    bus.rel = 1'b0;

    // timeout after 16 grant cycles, then regrant after one idle cycle
    bus.req = 32'h0000_0008; exp_q.push_back(3);
    tick();
    for (int c = 1; c < 16; c++) begin
      chk("t3_no_timeout", 32'(bus.timeout), 32'h0);
      tick();
    end
    chk("t3_timeout", 32'(bus.timeout), 32'h1);
    chk("t3_valid_at_timeout", 32'(bus.gnt_valid), 32'h1);
    exp_q.push_back(3);
    tick();
    chk_idle("t3_gap");
    tick();
    chk("t3_regrant_valid", 32'(bus.gnt_valid), 32'h1);
    bus.rel = 1'b1; bus.req = '0;
    tick();
    bus.rel = 1'b0;

    // enable gating
    bus.en = 1'b0; bus.req = 32'hFFFF_FFFF;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t4_gated_valid", 32'(bus.gnt_valid), 32'h0);
      chk("t4_gated_onehot", bus.gnt_onehot, 32'h0);
    end
    bus.en = 1'b1; exp_q.push_back(4);
    tick();
    bus.en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t4_hold_valid", 32'(bus.gnt_valid), 32'h1);
      chk("t4_hold_onehot", bus.gnt_onehot, 32'h0000_0010);
    end
    bus.rel = 1'b1;
    tick();
    chk_idle("t4_released");
    bus.rel = 1'b0; bus.req = '0; bus.en = 1'b1;
    tick();

    // rel in the cycle the hold counter reaches 15
    bus.req = 32'h0000_0020; exp_q.push_back(5);
    tick();
    ticks(15);
    bus.rel = 1'b1;
    #2;
    chk("t5_rel_beats_timeout", 32'(bus.timeout), 32'h0);
    chk("t5_valid", 32'(bus.gnt_valid), 32'h1);
    tick();
    chk_idle("t5_after");
    bus.rel = 1'b0; bus.req = '0;
    tick();

    // asynchronous reset mid-grant
    bus.req = 32'h0000_0080; exp_q.push_back(7);
    tick();
    ticks(2);
    chk("t6_owner", 32'(bus.gnt_idx), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("t6_reset");
    chk("t6_reset_idx", 32'(bus.gnt_idx), 32'h0);
    tick();
    rst_n = 1'b1; exp_q.push_back(7);
    tick();
    chk("t6_regrant_valid", 32'(bus.gnt_valid), 32'h1);
    bus.rel = 1'b1; bus.req = '0;
    tick();
    bus.rel = 1'b0;
    tick();

    chk("pending_grants", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
